// File: rtl/calc_ctrl_fsm_if.sv
// Keypad/ALU/display bundle for the calculator controller.
// master: the controller (consumes keys and ALU results, drives ALU operands and display).
// slave : the environment side (keypad decoder, ALU, display driver).
// Signals:
//   key_valid/key_code      keypad strobe and code (0-9 digit, A =, B AC, C-F operators)
//   alu_res/alu_done/alu_err ALU result, result-valid pulse, error qualifier
//   alu_a/alu_b/alu_op      ALU operands and operator, alu_start launch pulse
//   display                 BCD value for the display driver
//   busy/err                waiting on the ALU / error state
interface calc_ctrl_fsm_if #(
    parameter int unsigned DIGITS = 4
);
    localparam int unsigned W = 4 * DIGITS;

    logic         key_valid;
    logic [3:0]   key_code;
    logic [W-1:0] alu_res;
    logic         alu_done;
    logic         alu_err;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [3:0]   alu_op;
    logic         alu_start;
    logic [W-1:0] display;
    logic         busy;
    logic         err;

    modport master (
        input  key_valid, key_code, alu_res, alu_done, alu_err,
        output alu_a, alu_b, alu_op, alu_start, display, busy, err
    );

    modport slave (
        output key_valid, key_code, alu_res, alu_done, alu_err,
        input  alu_a, alu_b, alu_op, alu_start, display, busy, err
    );
endinterface

// File: rtl/calc_ctrl_fsm.sv
// Keypad-to-ALU controller for the calculator.
// Builds two BCD operands from keypad codes, launches the ALU with a start/done handshake,
// supports chained operators, repeat-equals, an ALU timeout and an error state.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  calc_ctrl_fsm_if.master: keypad inputs, ALU handshake, display/busy/err outputs
module calc_ctrl_fsm #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned ALU_TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    calc_ctrl_fsm_if.master bus
);
    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned CW = $clog2(DIGITS + 1);
    localparam int unsigned TW = (ALU_TIMEOUT > 1) ? $clog2(ALU_TIMEOUT) : 1;

    localparam logic [3:0] KeyEq = 4'hA;
    localparam logic [3:0] KeyAc = 4'hB;

    typedef enum logic [2:0] {StEnterA, StEnterB, StWaitAlu, StShowRes, StError} state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d, display_q, display_d;
    logic [CW-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic [3:0]    op_q, op_d, pend_q, pend_d;
    logic          chain_q, chain_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          start_q, start_d;
    logic          busy_q, err_q;

    logic key_dig, key_op, key_eq, key_ac;
    logic a_take, b_take;
    logic launch, clear_all;

    assign key_dig = bus.key_valid && (bus.key_code <= 4'd9);
    assign key_op  = bus.key_valid && (bus.key_code >= 4'hC);
    assign key_eq  = bus.key_valid && (bus.key_code == KeyEq);
    assign key_ac  = bus.key_valid && (bus.key_code == KeyAc);

    // Digit accepted while there is room; a zero into an empty operand is a leading zero
    assign a_take = (cnt_a_q < CW'(DIGITS)) && !((a_q == '0) && (bus.key_code == 4'd0));
    assign b_take = (cnt_b_q < CW'(DIGITS)) && !((b_q == '0) && (bus.key_code == 4'd0));

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        cnt_a_d   = cnt_a_q;
        cnt_b_d   = cnt_b_q;
        op_d      = op_q;
        pend_d    = pend_q;
        chain_d   = chain_q;
        tmo_d     = tmo_q;
        launch    = 1'b0;
        clear_all = 1'b0;

        unique case (state_q)
            StEnterA: begin
                if (key_dig) begin
                    if (a_take) begin
                        a_d     = W'({a_q, bus.key_code});
                        cnt_a_d = cnt_a_q + CW'(1);
                    end
                end else if (key_op) begin
                    op_d    = bus.key_code;
                    b_d     = '0;
                    cnt_b_d = '0;
                    state_d = StEnterB;
                end else if (key_ac) begin
                    a_d     = '0;
                    cnt_a_d = '0;
                end
            end
            StEnterB: begin
                if (key_dig) begin
                    if (b_take) begin
                        b_d     = W'({b_q, bus.key_code});
                        cnt_b_d = cnt_b_q + CW'(1);
                    end
                end else if (key_op) begin
                    if (cnt_b_q == '0) begin
                        op_d = bus.key_code;
                    end else begin
                        pend_d  = bus.key_code;
                        chain_d = 1'b1;
                        launch  = 1'b1;
                    end
                end else if (key_eq) begin
                    if (cnt_b_q != '0) begin
                        chain_d = 1'b0;
                        launch  = 1'b1;
                    end
                end else if (key_ac) begin
                    if (cnt_b_q != '0) begin
                        b_d     = '0;
                        cnt_b_d = '0;
                    end else begin
                        clear_all = 1'b1;
                    end
                end
            end
            StWaitAlu: begin
                // Abort beats a same-cycle done; done in the start cycle is ignored
                if (key_ac) begin
                    clear_all = 1'b1;
                end else if (bus.alu_done && !start_q) begin
                    if (bus.alu_err) begin
                        state_d = StError;
                    end else if (chain_q) begin
                        a_d     = bus.alu_res;
                        op_d    = pend_q;
                        b_d     = '0;
                        cnt_b_d = '0;
                        state_d = StEnterB;
                    end else begin
                        res_d   = bus.alu_res;
                        state_d = StShowRes;
                    end
                end else if (tmo_q == TW'(ALU_TIMEOUT - 1)) begin
                    state_d = StError;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            StShowRes: begin
                if (key_dig) begin
                    a_d     = W'(bus.key_code);
                    cnt_a_d = (bus.key_code != 4'd0) ? CW'(1) : '0;
                    state_d = StEnterA;
                end else if (key_op) begin
                    a_d     = res_q;
                    op_d    = bus.key_code;
                    b_d     = '0;
                    cnt_b_d = '0;
                    state_d = StEnterB;
                end else if (key_eq) begin
                    // Repeat-equals: previous b and operator are reused
                    a_d     = res_q;
                    chain_d = 1'b0;
                    launch  = 1'b1;
                end else if (key_ac) begin
                    clear_all = 1'b1;
                end
            end
            StError: begin
                if (key_ac) begin
                    clear_all = 1'b1;
                end
            end
            default: clear_all = 1'b1;
        endcase

        // The last result survives a clear
        if (clear_all) begin
            a_d     = '0;
            b_d     = '0;
            cnt_a_d = '0;
            cnt_b_d = '0;
            op_d    = '0;
            pend_d  = '0;
            chain_d = 1'b0;
            state_d = StEnterA;
        end

        if (launch) begin
            tmo_d   = '0;
            state_d = StWaitAlu;
        end
        start_d = launch;

        unique case (state_d)
            StEnterA:  display_d = a_d;
            StEnterB:  display_d = (cnt_b_d == '0) ? a_d : b_d;
            StShowRes: display_d = res_d;
            StError:   display_d = {DIGITS{4'hE}};
            default:   display_d = display_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StEnterA;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            cnt_a_q   <= '0;
            cnt_b_q   <= '0;
            op_q      <= '0;
            pend_q    <= '0;
            chain_q   <= 1'b0;
            tmo_q     <= '0;
            start_q   <= 1'b0;
            display_q <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            cnt_a_q   <= cnt_a_d;
            cnt_b_q   <= cnt_b_d;
            op_q      <= op_d;
            pend_q    <= pend_d;
            chain_q   <= chain_d;
            tmo_q     <= tmo_d;
            start_q   <= start_d;
            display_q <= display_d;
            busy_q    <= (state_d == StWaitAlu);
            err_q     <= (state_d == StError);
        end
    end

    // Operand registers double as the ALU operand outputs; they cannot change in WAIT_ALU
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
    assign bus.alu_op    = op_q;
    assign bus.alu_start = start_q;
    assign bus.display   = display_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
endmodule
